// File: rtl/hoplite_ni_pkg.sv
// Shared definitions for the Hoplite network interface: register map,
// STATUS bit positions and packet field layout helpers.
package hoplite_ni_pkg;

    // Write offsets (byte offset within the 0x80 window)
    localparam logic [6:0] OFF_TX_X      = 7'h00;
    localparam logic [6:0] OFF_TX_Y      = 7'h04;
    localparam logic [6:0] OFF_TX_MCAST  = 7'h08;
    localparam logic [6:0] OFF_TX_DONE   = 7'h0C;
    localparam logic [6:0] OFF_TX_RESULT = 7'h10;
    localparam logic [6:0] OFF_TX_TYPE   = 7'h14;
    localparam logic [6:0] OFF_TX_MX     = 7'h18;
    localparam logic [6:0] OFF_TX_MY     = 7'h1C;
    localparam logic [6:0] OFF_TX_ELEM   = 7'h20;
    localparam logic [6:0] OFF_TX_COMMIT = 7'h24;
    localparam logic [6:0] OFF_RX_POP    = 7'h28;
    localparam logic [6:0] OFF_CLEAR     = 7'h2C;

    // Read offsets
    localparam logic [6:0] OFF_STATUS    = 7'h40;
    localparam logic [6:0] OFF_RX_X      = 7'h44;
    localparam logic [6:0] OFF_RX_Y      = 7'h48;
    localparam logic [6:0] OFF_RX_MCAST  = 7'h4C;
    localparam logic [6:0] OFF_RX_DONE   = 7'h50;
    localparam logic [6:0] OFF_RX_RESULT = 7'h54;
    localparam logic [6:0] OFF_RX_TYPE   = 7'h58;
    localparam logic [6:0] OFF_RX_MX     = 7'h5C;
    localparam logic [6:0] OFF_RX_MY     = 7'h60;
    localparam logic [6:0] OFF_RX_ELEM   = 7'h64;
    localparam logic [6:0] OFF_TX_SENT   = 7'h68;
    localparam logic [6:0] OFF_RX_RECV   = 7'h6C;
    localparam logic [6:0] OFF_TX_DROPS  = 7'h70;

    localparam logic [31:0] WINDOW_BYTES = 32'h80;

    // STATUS bit positions
    localparam int unsigned ST_TX_NOT_FULL   = 0;
    localparam int unsigned ST_RX_NOT_EMPTY  = 1;
    localparam int unsigned ST_TX_OVERFLOW   = 2;
    localparam int unsigned ST_RX_UNDERFLOW  = 3;
    localparam int unsigned ST_TX_COUNT_LSB  = 8;
    localparam int unsigned ST_RX_COUNT_LSB  = 16;

    // Packet field indices, MSB first
    localparam int unsigned FLD_X      = 0;
    localparam int unsigned FLD_Y      = 1;
    localparam int unsigned FLD_MCAST  = 2;
    localparam int unsigned FLD_DONE   = 3;
    localparam int unsigned FLD_RESULT = 4;
    localparam int unsigned FLD_TYPE   = 5;
    localparam int unsigned FLD_MX     = 6;
    localparam int unsigned FLD_MY     = 7;
    localparam int unsigned FLD_ELEM   = 8;

    function automatic int unsigned pkt_bits(int unsigned cb, int unsigned mg, int unsigned mt,
                                             int unsigned mc, int unsigned me);
        return 2 * cb + mg + 2 + mt + 2 * mc + me;
    endfunction

    function automatic int unsigned field_width(int unsigned fld, int unsigned cb,
                                                int unsigned mg, int unsigned mt,
                                                int unsigned mc, int unsigned me);
        case (fld)
            FLD_X, FLD_Y:        return cb;
            FLD_MCAST:           return mg;
            FLD_DONE, FLD_RESULT: return 1;
            FLD_TYPE:            return mt;
            FLD_MX, FLD_MY:      return mc;
            default:             return me;
        endcase
    endfunction

    // LSB of a field = total width of all fields packed below it
    function automatic int unsigned field_lsb(int unsigned fld, int unsigned cb, int unsigned mg,
                                              int unsigned mt, int unsigned mc, int unsigned me);
        int unsigned lsb;
        lsb = 0;
        for (int unsigned f = FLD_ELEM; f > fld; f--) begin
            lsb += field_width(f, cb, mg, mt, mc, me);
        end
        return lsb;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Push is refused when full and pop
// is ignored when empty; fullness is judged on the count at the start of cycle.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/hoplite_net_interface.sv
// Memory-mapped network interface between a PicoRV32 look-ahead bus and a
// Hoplite router port, with staging registers and TX/RX packet FIFOs.
// Optional traffic counters are compiled in with NI_STATS_EN.
module hoplite_net_interface
    import hoplite_ni_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR            = 32'h4000_0000,
    parameter int unsigned TX_DEPTH             = 4,
    parameter int unsigned RX_DEPTH             = 4,
    parameter int unsigned COORD_BITS           = 1,
    parameter int unsigned MULTICAST_GROUP_BITS = 1,
    parameter int unsigned MATRIX_TYPE_BITS     = 1,
    parameter int unsigned MATRIX_COORD_BITS    = 8,
    parameter int unsigned MATRIX_ELEMENT_BITS  = 32,
    localparam int unsigned PKT_BITS = pkt_bits(COORD_BITS, MULTICAST_GROUP_BITS,
        MATRIX_TYPE_BITS, MATRIX_COORD_BITS, MATRIX_ELEMENT_BITS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [31:0]         wr_addr,
    input  logic [31:0]         wr_data,
    input  logic                rd_en,
    input  logic [31:0]         rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_hit,
    output logic [PKT_BITS-1:0] tx_packet,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [PKT_BITS-1:0] rx_packet,
    input  logic                rx_valid,
    output logic                rx_ready
);

    localparam int unsigned CB = COORD_BITS;
    localparam int unsigned MG = MULTICAST_GROUP_BITS;
    localparam int unsigned MT = MATRIX_TYPE_BITS;
    localparam int unsigned MC = MATRIX_COORD_BITS;
    localparam int unsigned ME = MATRIX_ELEMENT_BITS;
    localparam int unsigned X_LSB      = field_lsb(FLD_X, CB, MG, MT, MC, ME);
    localparam int unsigned Y_LSB      = field_lsb(FLD_Y, CB, MG, MT, MC, ME);
    localparam int unsigned MCAST_LSB  = field_lsb(FLD_MCAST, CB, MG, MT, MC, ME);
    localparam int unsigned DONE_LSB   = field_lsb(FLD_DONE, CB, MG, MT, MC, ME);
    localparam int unsigned RESULT_LSB = field_lsb(FLD_RESULT, CB, MG, MT, MC, ME);
    localparam int unsigned TYPE_LSB   = field_lsb(FLD_TYPE, CB, MG, MT, MC, ME);
    localparam int unsigned MX_LSB     = field_lsb(FLD_MX, CB, MG, MT, MC, ME);
    localparam int unsigned MY_LSB     = field_lsb(FLD_MY, CB, MG, MT, MC, ME);
    localparam int unsigned ELEM_LSB   = field_lsb(FLD_ELEM, CB, MG, MT, MC, ME);
    localparam int unsigned TX_CW = $clog2(TX_DEPTH + 1);
    localparam int unsigned RX_CW = $clog2(RX_DEPTH + 1);

    logic [31:0] wr_off, rd_off;
    logic [6:0]  wr_idx, rd_idx;
    logic        wr_sel, rd_sel;
    logic        tx_push, rx_pop_req, clear_req;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [TX_CW-1:0] tx_count;
    logic [RX_CW-1:0] rx_count;
    logic [PKT_BITS-1:0] tx_stage, rx_head;
    logic        tx_overflow_q, rx_underflow_q;
    logic [31:0] status_word, rd_word;

    logic [CB-1:0] st_x_q, st_y_q;
    logic [MG-1:0] st_mcast_q;
    logic          st_done_q, st_result_q;
    logic [MT-1:0] st_type_q;
    logic [MC-1:0] st_mx_q, st_my_q;
    logic [ME-1:0] st_elem_q;

    // Out-of-window addresses wrap to large offsets, so one compare decodes the window
    assign wr_off     = wr_addr - BASE_ADDR;
    assign rd_off     = rd_addr - BASE_ADDR;
    assign wr_idx     = wr_off[6:0];
    assign rd_idx     = rd_off[6:0];
    assign wr_sel     = wr_en && (wr_off < WINDOW_BYTES);
    assign rd_sel     = rd_en && (rd_off < WINDOW_BYTES);
    assign tx_push    = wr_sel && (wr_idx == OFF_TX_COMMIT);
    assign rx_pop_req = wr_sel && (wr_idx == OFF_RX_POP);
    assign clear_req  = wr_sel && (wr_idx == OFF_CLEAR) && wr_data[0];

    // Commit captures the current staging registers, i.e. pre-write values
    assign tx_stage = {st_x_q, st_y_q, st_mcast_q, st_done_q, st_result_q, st_type_q,
                       st_mx_q, st_my_q, st_elem_q};
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    // Staging register writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_x_q <= '0; st_y_q <= '0; st_mcast_q <= '0; st_done_q <= 1'b0;
            st_result_q <= 1'b0; st_type_q <= '0; st_mx_q <= '0; st_my_q <= '0;
            st_elem_q <= '0;
        end else if (wr_sel) begin
            case (wr_idx)
                OFF_TX_X:      st_x_q      <= wr_data[CB-1:0];
                OFF_TX_Y:      st_y_q      <= wr_data[CB-1:0];
                OFF_TX_MCAST:  st_mcast_q  <= wr_data[MG-1:0];
                OFF_TX_DONE:   st_done_q   <= wr_data[0];
                OFF_TX_RESULT: st_result_q <= wr_data[0];
                OFF_TX_TYPE:   st_type_q   <= wr_data[MT-1:0];
                OFF_TX_MX:     st_mx_q     <= wr_data[MC-1:0];
                OFF_TX_MY:     st_my_q     <= wr_data[MC-1:0];
                OFF_TX_ELEM:   st_elem_q   <= wr_data[ME-1:0];
                default: ;
            endcase
        end
    end

    sync_fifo_fwft #(.WIDTH(PKT_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (tx_stage),
        .pop       (tx_ready),
        .pop_data  (tx_packet),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo_fwft #(.WIDTH(PKT_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_valid),
        .push_data (rx_packet),
        .pop       (rx_pop_req),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Sticky error flags; CLEAR and error events are both bus writes, never coincident
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else if (clear_req) begin
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            if (tx_push && tx_full)     tx_overflow_q  <= 1'b1;
            if (rx_pop_req && rx_empty) rx_underflow_q <= 1'b1;
        end
    end

`ifdef NI_STATS_EN
    logic [31:0] tx_sent_q, rx_recv_q, tx_drops_q;

    // Traffic counters; CLEAR wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!reset_n || clear_req) begin
            tx_sent_q  <= '0;
            rx_recv_q  <= '0;
            tx_drops_q <= '0;
        end else begin
            if (tx_ready && !tx_empty) tx_sent_q  <= tx_sent_q + 32'd1;
            if (rx_valid && !rx_full)  rx_recv_q  <= rx_recv_q + 32'd1;
            if (tx_push && tx_full)    tx_drops_q <= tx_drops_q + 32'd1;
        end
    end
`endif

    // STATUS word assembly
    always_comb begin
        status_word = '0;
        status_word[ST_TX_NOT_FULL]  = !tx_full;
        status_word[ST_RX_NOT_EMPTY] = !rx_empty;
        status_word[ST_TX_OVERFLOW]  = tx_overflow_q;
        status_word[ST_RX_UNDERFLOW] = rx_underflow_q;
        status_word[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
        status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
    end

    // Read decode; RX head fields read 0 while the RX FIFO is empty
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            OFF_STATUS:    rd_word = status_word;
            OFF_RX_X:      rd_word = 32'(rx_head[X_LSB +: CB]);
            OFF_RX_Y:      rd_word = 32'(rx_head[Y_LSB +: CB]);
            OFF_RX_MCAST:  rd_word = 32'(rx_head[MCAST_LSB +: MG]);
            OFF_RX_DONE:   rd_word = 32'(rx_head[DONE_LSB]);
            OFF_RX_RESULT: rd_word = 32'(rx_head[RESULT_LSB]);
            OFF_RX_TYPE:   rd_word = 32'(rx_head[TYPE_LSB +: MT]);
            OFF_RX_MX:     rd_word = 32'(rx_head[MX_LSB +: MC]);
            OFF_RX_MY:     rd_word = 32'(rx_head[MY_LSB +: MC]);
            OFF_RX_ELEM:   rd_word = 32'(rx_head[ELEM_LSB +: ME]);
`ifdef NI_STATS_EN
            OFF_TX_SENT:   rd_word = tx_sent_q;
            OFF_RX_RECV:   rd_word = rx_recv_q;
            OFF_TX_DROPS:  rd_word = tx_drops_q;
`endif
            default:       rd_word = '0;
        endcase
        if (rx_empty && rd_idx >= OFF_RX_X && rd_idx <= OFF_RX_ELEM) rd_word = '0;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
        end else begin
            rd_hit  <= rd_sel;
            rd_data <= rd_sel ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_hoplite_net_interface.sv
// Self-checking bench for hoplite_net_interface: directed test-plan sequences,
// a table of read-decode vectors, and randomized traffic against a queue model.
module tb_hoplite_net_interface;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int unsigned PB = 54;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW [9] = '{1, 1, 1, 1, 1, 1, 8, 8, 32};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, rd_en;
    logic [31:0]   wr_addr, wr_data, rd_addr;
    logic [31:0]   rd_data;
    logic          rd_hit;
    logic [PB-1:0] tx_packet, rx_packet;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;

    int total = 0;
    int bad = 0;

    hoplite_net_interface dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .tx_packet (tx_packet),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t vecs [18];

    // Reference model state
    logic [PB-1:0] txq [$];
    logic [PB-1:0] rxq [$];
    logic [31:0]   st [9];
    logic          ovf, unf;
    logic [31:0]   sent, recv, drops;

    function automatic logic [63:0] fmask(int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [PB-1:0] pack_arr(input logic [31:0] f [9]);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p = (p << FW[i]) | (64'(f[i]) & fmask(FW[i]));
        return p[PB-1:0];
    endfunction

    function automatic logic [PB-1:0] pack9(logic [31:0] x, logic [31:0] y, logic [31:0] m,
                                            logic [31:0] d, logic [31:0] r, logic [31:0] t,
                                            logic [31:0] mx, logic [31:0] my,
                                            logic [31:0] e);
        logic [31:0] f [9];
        f[0] = x; f[1] = y; f[2] = m; f[3] = d; f[4] = r; f[5] = t; f[6] = mx; f[7] = my;
        f[8] = e;
        return pack_arr(f);
    endfunction

    function automatic logic [31:0] field_of(logic [PB-1:0] p, int idx);
        int unsigned lsb;
        lsb = 0;
        for (int j = idx + 1; j < 9; j++) lsb += FW[j];
        return 32'((64'(p) >> lsb) & fmask(FW[idx]));
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = txq.size() < DEPTH;
        s[1] = rxq.size() > 0;
        s[2] = ovf;
        s[3] = unf;
        s[15:8]  = 8'(txq.size());
        s[23:16] = 8'(rxq.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read(int off);
        if (off == 'h40) return model_status();
        if (off >= 'h44 && off <= 'h64) begin
            if (rxq.size() == 0) return '0;
            return field_of(rxq[0], (off - 'h44) / 4);
        end
`ifdef NI_STATS_EN
        if (off == 'h68) return sent;
        if (off == 'h6C) return recv;
        if (off == 'h70) return drops;
`endif
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [6:0] off, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = BASE + 32'(off); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data; h = rd_hit;
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        logic [31:0] d;
        logic h;
        bus_rd(BASE + 32'h40, d, h);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic inject(input logic [PB-1:0] p);
        rx_valid = 1'b1; rx_packet = p;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic h;
        logic [31:0] exp_data;
        logic exp_hit;
        logic [31:0] stats_rx;

        reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_packet = '0;
        do_reset();

        // Reset state
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_hit", 64'(rd_hit), 64'd0);
        chk("reset_tx_valid", 64'(tx_valid), 64'd0);
        chk("reset_rx_ready", 64'(rx_ready), 64'd1);
        rd_status("reset_status", 32'h0000_0001);

        // First commit with router stalled
        bus_wr(7'h00, 32'd1);
        bus_wr(7'h04, 32'd0);
        bus_wr(7'h20, 32'hDEAD_BEEF);
        bus_wr(7'h24, 32'd0);
        chk("commit_tx_valid", 64'(tx_valid), 64'd1);
        chk("commit_elem", 64'(tx_packet[31:0]), 64'hDEAD_BEEF);
        chk("commit_packet", 64'(tx_packet), 64'(pack9(1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF)));
        rd_status("commit_status", 32'h0000_0101);

        // Four more commits: the fifth overall is dropped
        repeat (4) bus_wr(7'h24, 32'd0);
        rd_status("overflow_status", 32'h0000_0404);
        bus_rd(BASE + 32'h70, d, h);
`ifdef NI_STATS_EN
        chk("tx_drops", 64'(d), 64'd1);
`else
        chk("tx_drops_absent", 64'(d), 64'd0);
`endif
        chk("fwft_stable", 64'(tx_packet), 64'(pack9(1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF)));
        bus_wr(7'h2C, 32'd1);
        rd_status("clear_status", 32'h0000_0400);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        rd_status("drain_one_status", 32'h0000_0301);

        // RX fill to full
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            chk("rx_ready_before_fill", 64'(rx_ready), 64'd1);
            inject(pack9(0, 1, 0, 0, 0, 0, 0, 0, 32'(i)));
        end
        chk("rx_ready_full", 64'(rx_ready), 64'd0);
        bus_rd(BASE + 32'h64, d, h);
        chk("rx_head_1", 64'(d), 64'd1);
        bus_wr(7'h28, 32'd0);
        bus_rd(BASE + 32'h64, d, h);
        chk("rx_head_2", 64'(d), 64'd2);
        inject(pack9(0, 1, 0, 0, 0, 0, 0, 0, 32'd5));
        chk("rx_ready_refull", 64'(rx_ready), 64'd0);

        // Pop and incoming packet together while full: pop happens, packet rejected
        wr_en = 1'b1; wr_addr = BASE + 32'h28; wr_data = '0;
        rx_valid = 1'b1; rx_packet = pack9(0, 1, 0, 0, 0, 0, 0, 0, 32'd99);
        @(negedge clk);
        wr_en = 1'b0; rx_valid = 1'b0;
        rd_status("full_pop_push_status", 32'h0003_0003);
        for (int i = 3; i <= 5; i++) begin
            bus_rd(BASE + 32'h64, d, h);
            chk("rx_drain_order", 64'(d), 64'(i));
            bus_wr(7'h28, 32'd0);
        end
        bus_rd(BASE + 32'h64, d, h);
        chk("rx_empty_field", 64'(d), 64'd0);

        // Underflow
        bus_wr(7'h28, 32'd0);
        rd_status("underflow_status", 32'h0000_0009);

        // Reset mid-stream
        do_reset();
        repeat (3) bus_wr(7'h24, 32'd0);
        rd_status("three_commits_status", 32'h0000_0301);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_tx_valid", 64'(tx_valid), 64'd0);
        reset_n = 1'b1;
        rd_status("midreset_status", 32'h0000_0001);
        bus_wr(7'h24, 32'd0);
        chk("staging_cleared", 64'(tx_packet), 64'd0);

        // Read-decode table with one known packet in RX
        do_reset();
        inject(pack9(1, 0, 1, 0, 1, 1, 32'hA5, 32'h3C, 32'h1234_5678));
`ifdef NI_STATS_EN
        stats_rx = 32'd1;
`else
        stats_rx = 32'd0;
`endif
        vecs[0]  = '{BASE + 32'h40, 1'b1, 32'h0001_0003};
        vecs[1]  = '{BASE + 32'h44, 1'b1, 32'd1};
        vecs[2]  = '{BASE + 32'h48, 1'b1, 32'd0};
        vecs[3]  = '{BASE + 32'h4C, 1'b1, 32'd1};
        vecs[4]  = '{BASE + 32'h50, 1'b1, 32'd0};
        vecs[5]  = '{BASE + 32'h54, 1'b1, 32'd1};
        vecs[6]  = '{BASE + 32'h58, 1'b1, 32'd1};
        vecs[7]  = '{BASE + 32'h5C, 1'b1, 32'hA5};
        vecs[8]  = '{BASE + 32'h60, 1'b1, 32'h3C};
        vecs[9]  = '{BASE + 32'h64, 1'b1, 32'h1234_5678};
        vecs[10] = '{BASE + 32'h30, 1'b1, 32'd0};
        vecs[11] = '{BASE + 32'h7C, 1'b1, 32'd0};
        vecs[12] = '{BASE + 32'h68, 1'b1, 32'd0};
        vecs[13] = '{BASE + 32'h6C, 1'b1, stats_rx};
        vecs[14] = '{BASE + 32'h70, 1'b1, 32'd0};
        vecs[15] = '{BASE - 32'h4, 1'b0, 32'd0};
        vecs[16] = '{BASE + 32'h80, 1'b0, 32'd0};
        vecs[17] = '{32'h0000_0040, 1'b0, 32'd0};
        for (int i = 0; i < 18; i++) begin
            bus_rd(vecs[i].addr, d, h);
            chk($sformatf("vec%0d_hit", i), 64'(h), 64'(vecs[i].hit));
            chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].data));
        end

        // Randomized traffic against the queue model
        do_reset();
        txq.delete(); rxq.delete();
        for (int i = 0; i < 9; i++) st[i] = '0;
        ovf = 1'b0; unf = 1'b0; sent = '0; recv = '0; drops = '0;
        exp_hit = 1'b0; exp_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int op;
            int fld;
            int r;
            logic tx_full0, rx_full0, rx_empty0;
            logic [PB-1:0] pkt;

            chk("rand_rd_hit", 64'(rd_hit), 64'(exp_hit));
            chk("rand_rd_data", 64'(rd_data), 64'(exp_data));
            chk("rand_tx_valid", 64'(tx_valid), 64'(txq.size() > 0));
            chk("rand_rx_ready", 64'(rx_ready), 64'(rxq.size() < DEPTH));
            if (txq.size() > 0) chk("rand_tx_packet", 64'(tx_packet), 64'(txq[0]));

            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            pkt = PB'({$urandom, $urandom});
            rx_packet = pkt;
            op = $urandom_range(0, 19);
            fld = $urandom_range(0, 8);
            wr_data = $urandom;
            wr_en = 1'b1;
            if (op < 6)       wr_addr = BASE + 32'(fld * 4);
            else if (op < 10) wr_addr = BASE + 32'h24;
            else if (op < 14) wr_addr = BASE + 32'h28;
            else if (op == 19) wr_addr = BASE + 32'h2C;
            else wr_en = 1'b0;

            rd_en = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 7);
            if (r == 0)      rd_addr = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) rd_addr = BASE + 32'h80 + 32'(4 * $urandom_range(0, 7));
            else             rd_addr = BASE + 32'(4 * $urandom_range(0, 31));
            exp_hit = rd_en && (r > 1);
            exp_data = exp_hit ? model_read(int'(rd_addr - BASE)) : 32'd0;

            tx_full0 = (txq.size() == DEPTH);
            rx_full0 = (rxq.size() == DEPTH);
            rx_empty0 = (rxq.size() == 0);
            if (tx_ready && txq.size() > 0) begin
                void'(txq.pop_front());
                sent++;
            end
            if (wr_en && op >= 6 && op < 10) begin
                if (!tx_full0) txq.push_back(pack_arr(st));
                else begin
                    ovf = 1'b1;
                    drops++;
                end
            end
            if (rx_valid && !rx_full0) begin
                rxq.push_back(pkt);
                recv++;
            end
            if (wr_en && op >= 10 && op < 14) begin
                if (!rx_empty0) void'(rxq.pop_front());
                else unf = 1'b1;
            end
            if (wr_en && op == 19 && wr_data[0]) begin
                ovf = 1'b0; unf = 1'b0; sent = '0; recv = '0; drops = '0;
            end
            if (wr_en && op < 6) st[fld] = 32'(64'(wr_data) & fmask(FW[fld]));

            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
